// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 32-entry register file and its
// write-select decoder.
//   NUM_REGS        : number of architectural registers
//   REG_ADDR_W      : width of a register number
//   ZERO_REG        : register number that is hardwired to zero
//   DEFAULT_DATA_W  : default register width
//   reg_addr_t      : register number type
//   reg_sel_t       : one-hot write-select word
//   word_t          : register word at the default width; blocks built with a
//                     non-default DATA_WIDTH declare the same shape locally
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int NUM_REGS       = 32;
    localparam int REG_ADDR_W     = 5;
    localparam int DEFAULT_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0]     reg_addr_t;
    typedef logic [NUM_REGS-1:0]       reg_sel_t;
    typedef logic [DEFAULT_DATA_W-1:0] word_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file32_if.sv
// -----------------------------------------------------------------------------
// register_file32_if
// Read/write bus between the datapath and the register file.
//   read_reg1/2  : read port register numbers (datapath -> regfile)
//   write_reg    : destination register number (datapath -> regfile)
//   write_data   : value to store (datapath -> regfile)
//   reg_write    : write enable for this cycle (datapath -> regfile)
//   read_data1/2 : read port data (regfile -> datapath)
// Modports: master = datapath side, slave = register file side.
// -----------------------------------------------------------------------------
interface register_file32_if #(
    parameter int DATA_WIDTH = 32
);
    import regfile_pkg::*;

    reg_addr_t             read_reg1;
    reg_addr_t             read_reg2;
    reg_addr_t             write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  reg_write;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;

    modport master (
        output read_reg1, read_reg2, write_reg, write_data, reg_write,
        input  read_data1, read_data2
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, reg_write,
        output read_data1, read_data2
    );

endinterface

// File: rtl/decoder5_32.sv
// -----------------------------------------------------------------------------
// decoder5_32
// 5-to-32 one-hot decoder.
//   in  : 5-bit binary index
//   out : one-hot word, bit `in` set, all others clear
// -----------------------------------------------------------------------------
module decoder5_32
    import regfile_pkg::*;
(
    input  reg_addr_t in,
    output reg_sel_t  out
);

    assign out = reg_sel_t'(1) << in;

endmodule

// File: rtl/register_file32.sv
// -----------------------------------------------------------------------------
// register_file32
// 32-entry register file with two asynchronous read ports and one synchronous
// write port. Register 0 is hardwired to zero. With BYPASS=1 a read of the
// register being written this cycle returns write_data (write-through).
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high; clears every register, beats any write
//   bus   : register_file32_if slave (read_reg1/2, write_reg, write_data,
//           reg_write in; read_data1/2 out)
// -----------------------------------------------------------------------------
module register_file32
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1
) (
    input  logic              clk,
    input  logic              reset,
    register_file32_if.slave  bus
);

    typedef logic [DATA_WIDTH-1:0] data_t;

    data_t    regs [NUM_REGS];
    reg_sel_t sel;
    reg_sel_t we;

    decoder5_32 u_write_decode (
        .in  (bus.write_reg),
        .out (sel)
    );

    assign we = sel & {NUM_REGS{bus.reg_write}};

    // NOTE: the array is cleared by reset because the datapath relies on all
    // registers reading 0 after reset; it therefore maps to flops, not a RAM.
    // Non-blocking assignments keep every register update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // Entry 0 is excluded so a write to r0 is dropped.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we[i] && (i != 0)) begin
                    regs[i] <= bus.write_data;
                end
            end
        end
    end

    // Forwarding applies only to a real write to a nonzero register.
    logic write_live;
    assign write_live = (BYPASS != 0) && bus.reg_write && (bus.write_reg != ZERO_REG);

    data_t rd1;
    data_t rd2;

    // NOTE: each output gets a default before the conditional overrides so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (bus.read_reg1 != ZERO_REG) rd1 = regs[bus.read_reg1];
        if (bus.read_reg2 != ZERO_REG) rd2 = regs[bus.read_reg2];
        if (write_live && (bus.read_reg1 == bus.write_reg)) rd1 = bus.write_data;
        if (write_live && (bus.read_reg2 == bus.write_reg)) rd2 = bus.write_data;
    end

    assign bus.read_data1 = rd1;
    assign bus.read_data2 = rd2;

endmodule

// File: tb/tb_register_file32.sv
// -----------------------------------------------------------------------------
// tb_register_file32
// Drives one register file built with BYPASS=1 (dut_b) and one with BYPASS=0
// (dut_n) from the same stimulus and compares both against hand-computed
// expected values.
// -----------------------------------------------------------------------------
module tb_register_file32;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    register_file32_if #(.DATA_WIDTH(32)) bus_b ();
    register_file32_if #(.DATA_WIDTH(32)) bus_n ();

    assign bus_b.read_reg1  = read_reg1;
    assign bus_b.read_reg2  = read_reg2;
    assign bus_b.write_reg  = write_reg;
    assign bus_b.write_data = write_data;
    assign bus_b.reg_write  = reg_write;
    assign bus_n.read_reg1  = read_reg1;
    assign bus_n.read_reg2  = read_reg2;
    assign bus_n.write_reg  = write_reg;
    assign bus_n.write_data = write_data;
    assign bus_n.reg_write  = reg_write;

    register_file32 #(.DATA_WIDTH(32), .BYPASS(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    register_file32 #(.DATA_WIDTH(32), .BYPASS(0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n)
    );

    // Advance past the next rising edge; inputs change and outputs are sampled
    // well away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_reg_now(input logic [4:0] addr, input logic [31:0] data);
        reg_write  = 1'b1;
        write_reg  = addr;
        write_data = data;
        tick();
        reg_write  = 1'b0;
        #1;
    endtask

    // Sweep ports over all addresses; expected value comes from the table.
    task automatic sweep_expect(input string name, input logic [31:0] exp_tab [32]);
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            #1;
            tests++;
            if (bus_b.read_data1 !== exp_tab[i] || bus_n.read_data1 !== exp_tab[i]) begin
                fails++;
                $display("FAIL %s port1 r%0d: got b=%h n=%h want %h", name, i,
                         bus_b.read_data1, bus_n.read_data1, exp_tab[i]);
            end
            tests++;
            if (bus_b.read_data2 !== exp_tab[31-i] || bus_n.read_data2 !== exp_tab[31-i]) begin
                fails++;
                $display("FAIL %s port2 r%0d: got b=%h n=%h want %h", name, 31 - i,
                         bus_b.read_data2, bus_n.read_data2, exp_tab[31-i]);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] exp_tab [32];
        for (int i = 0; i < 32; i++) exp_tab[i] = 32'h0;
        reg_write = 1'b0; write_reg = 5'd0; write_data = 32'h0;
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sweep_expect("reset_sweep", exp_tab);
    endtask

    task automatic test_write_readback();
        logic [31:0] exp_tab [32];
        write_reg_now(5'd5, 32'hDEADBEEF);
        write_reg_now(5'd31, 32'h12345678);
        read_reg1 = 5'd5; read_reg2 = 5'd31;
        #1;
        tests++;
        if (bus_b.read_data1 !== 32'hDEADBEEF || bus_n.read_data1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL readback_r5: got b=%h n=%h want deadbeef", bus_b.read_data1, bus_n.read_data1);
        end
        tests++;
        if (bus_b.read_data2 !== 32'h12345678 || bus_n.read_data2 !== 32'h12345678) begin
            fails++;
            $display("FAIL readback_r31: got b=%h n=%h want 12345678", bus_b.read_data2, bus_n.read_data2);
        end
        for (int i = 0; i < 32; i++) exp_tab[i] = 32'h0;
        exp_tab[5]  = 32'hDEADBEEF;
        exp_tab[31] = 32'h12345678;
        sweep_expect("readback_sweep", exp_tab);
    endtask

    task automatic test_zero_reg();
        logic [31:0] exp_tab [32];
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        #1;
        // A write to r0 must never be forwarded.
        tests++;
        if (bus_b.read_data1 !== 32'h0 || bus_b.read_data2 !== 32'h0) begin
            fails++;
            $display("FAIL zero_no_bypass: got p1=%h p2=%h want 0", bus_b.read_data1, bus_b.read_data2);
        end
        tick();
        reg_write = 1'b0;
        #1;
        tests++;
        if (bus_b.read_data1 !== 32'h0 || bus_n.read_data1 !== 32'h0) begin
            fails++;
            $display("FAIL zero_after_write: got b=%h n=%h want 0", bus_b.read_data1, bus_n.read_data1);
        end
        for (int i = 0; i < 32; i++) exp_tab[i] = 32'h0;
        exp_tab[5]  = 32'hDEADBEEF;
        exp_tab[31] = 32'h12345678;
        sweep_expect("zero_others", exp_tab);
    endtask

    task automatic test_write_enable_low();
        reg_write = 1'b0; write_reg = 5'd7; write_data = 32'hAAAA5555;
        read_reg1 = 5'd7; read_reg2 = 5'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (bus_b.read_data1 !== 32'h0 || bus_n.read_data2 !== 32'h0) begin
                fails++;
                $display("FAIL we_low_cycle%0d: got b=%h n=%h want 0", c, bus_b.read_data1, bus_n.read_data2);
            end
            tick();
        end
        write_reg = 5'd0;
        #1;
        tests++;
        if (bus_b.read_data1 !== 32'h0 || bus_n.read_data1 !== 32'h0) begin
            fails++;
            $display("FAIL we_low_r7: got b=%h n=%h want 0", bus_b.read_data1, bus_n.read_data1);
        end
    endtask

    task automatic test_same_cycle();
        write_reg_now(5'd9, 32'h1);
        read_reg1 = 5'd9; read_reg2 = 5'd9;
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h2;
        #1;
        tests++;
        if (bus_b.read_data1 !== 32'h2 || bus_b.read_data2 !== 32'h2) begin
            fails++;
            $display("FAIL same_cycle_bypass: got p1=%h p2=%h want 2", bus_b.read_data1, bus_b.read_data2);
        end
        tests++;
        if (bus_n.read_data1 !== 32'h1 || bus_n.read_data2 !== 32'h1) begin
            fails++;
            $display("FAIL same_cycle_nobypass: got p1=%h p2=%h want 1", bus_n.read_data1, bus_n.read_data2);
        end
        // Only the addressed port is forwarded.
        read_reg2 = 5'd5;
        #1;
        tests++;
        if (bus_b.read_data2 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL bypass_other_port: got %h want deadbeef", bus_b.read_data2);
        end
        read_reg2 = 5'd9;
        tick();
        reg_write = 1'b0;
        #1;
        tests++;
        if (bus_b.read_data1 !== 32'h2 || bus_n.read_data1 !== 32'h2 ||
            bus_b.read_data2 !== 32'h2 || bus_n.read_data2 !== 32'h2) begin
            fails++;
            $display("FAIL same_cycle_after: got b=%h/%h n=%h/%h want 2", bus_b.read_data1,
                     bus_b.read_data2, bus_n.read_data1, bus_n.read_data2);
        end
    endtask

    task automatic test_reset_priority();
        logic [31:0] exp_tab [32];
        write_reg_now(5'd3, 32'h77);
        read_reg1 = 5'd3; read_reg2 = 5'd3;
        #1;
        tests++;
        if (bus_b.read_data1 !== 32'h77 || bus_n.read_data1 !== 32'h77) begin
            fails++;
            $display("FAIL prio_r3_stored: got b=%h n=%h want 77", bus_b.read_data1, bus_n.read_data1);
        end
        reset = 1'b1; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h99;
        #1;
        tests++;
        if (bus_b.read_data1 !== 32'h99 || bus_n.read_data1 !== 32'h77) begin
            fails++;
            $display("FAIL prio_reset_cycle: got b=%h n=%h want b=99 n=77", bus_b.read_data1, bus_n.read_data1);
        end
        tick();
        reset = 1'b0; reg_write = 1'b0;
        #1;
        tests++;
        if (bus_b.read_data1 !== 32'h0 || bus_n.read_data1 !== 32'h0) begin
            fails++;
            $display("FAIL prio_r3_cleared: got b=%h n=%h want 0", bus_b.read_data1, bus_n.read_data1);
        end
        for (int i = 0; i < 32; i++) exp_tab[i] = 32'h0;
        sweep_expect("prio_all_cleared", exp_tab);
        write_reg_now(5'd3, 32'h99);
        read_reg1 = 5'd3; read_reg2 = 5'd3;
        #1;
        tests++;
        if (bus_b.read_data1 !== 32'h99 || bus_n.read_data2 !== 32'h99) begin
            fails++;
            $display("FAIL prio_write_after: got b=%h n=%h want 99", bus_b.read_data1, bus_n.read_data2);
        end
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0; write_reg = 5'd0; write_data = 32'h0;
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        @(negedge clk);
        test_reset();
        test_write_readback();
        test_zero_reg();
        test_write_enable_low();
        test_same_cycle();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
